// File: rtl/qc_inspector.sv
// Quality-control inspection responder: settles, averages NSAMP sensor samples,
// classifies the average against [LO, HI] and holds a POK/PNOK verdict until acknowledged.
module qc_inspector #(
    parameter int unsigned W           = 8,
    parameter int unsigned LOG2_NSAMP  = 2,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned LO          = 100,
    parameter int unsigned HI          = 150
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         DCE,
    input  logic         ME,
    input  logic         MS,
    input  logic         SVALID,
    input  logic [W-1:0] SAMPLE,
    output logic         POK,
    output logic         PNOK,
    output logic         BUSY,
    output logic         ERR,
    output logic [7:0]   OK_CNT,
    output logic [7:0]   NOK_CNT
);

    localparam int unsigned NSAMP = 1 << LOG2_NSAMP;
    localparam int unsigned SW    = W + LOG2_NSAMP;
    localparam int unsigned NW    = LOG2_NSAMP + 1;
    localparam int unsigned CMAX  = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int unsigned CW    = $clog2(CMAX + 1);

    localparam logic [W-1:0]  LO_V         = W'(LO);
    localparam logic [W-1:0]  HI_V         = W'(HI);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [NW-1:0] NSAMP_LAST   = NW'(NSAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_REPORT,
        S_WAIT_CLEAR
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cyc, cyc_d;
    logic [NW-1:0] nsamp, nsamp_d;
    logic [SW-1:0] sum, sum_d;
    logic          pok_d, pnok_d, err_d, busy_d;
    logic [7:0]    ok_d, nok_d;

    logic          abort;
    logic          last_sample;
    logic          timed_out;
    logic [W-1:0]  avg;
    logic          pass;

    assign abort       = !DCE || ME;
    assign last_sample = SVALID && (nsamp == NSAMP_LAST);
    assign timed_out   = (cyc == TIMEOUT_LAST);
    assign avg         = sum[SW-1:LOG2_NSAMP];
    assign pass        = (avg >= LO_V) && (avg <= HI_V);

    // State and every output are registered together; outputs carry no input-to-output path.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            cyc     <= '0;
            nsamp   <= '0;
            sum     <= '0;
            POK     <= 1'b0;
            PNOK    <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            OK_CNT  <= '0;
            NOK_CNT <= '0;
        end else begin
            state   <= next_state;
            cyc     <= cyc_d;
            nsamp   <= nsamp_d;
            sum     <= sum_d;
            POK     <= pok_d;
            PNOK    <= pnok_d;
            ERR     <= err_d;
            BUSY    <= busy_d;
            OK_CNT  <= ok_d;
            NOK_CNT <= nok_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (DCE && !ME)
                    next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)
                    next_state = S_IDLE;
                else if (cyc == SETTLE_LAST)
                    next_state = S_MEASURE;
            end
            S_MEASURE: begin
                // A final sample landing in the timeout cycle still counts as a measurement.
                if (abort)
                    next_state = S_IDLE;
                else if (last_sample)
                    next_state = S_DECIDE;
                else if (timed_out)
                    next_state = S_REPORT;
            end
            S_DECIDE: begin
                if (abort)
                    next_state = S_IDLE;
                else
                    next_state = S_REPORT;
            end
            S_REPORT: begin
                if (MS)
                    next_state = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                if (!DCE)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d   = cyc;
        nsamp_d = nsamp;
        sum_d   = sum;
        pok_d   = POK;
        pnok_d  = PNOK;
        err_d   = ERR;
        ok_d    = OK_CNT;
        nok_d   = NOK_CNT;
        busy_d  = (next_state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (next_state == S_SETTLE) begin
                    cyc_d   = '0;
                    nsamp_d = '0;
                    sum_d   = '0;
                end
            end
            S_SETTLE: begin
                cyc_d = (next_state == S_SETTLE) ? cyc + 1'b1 : '0;
            end
            S_MEASURE: begin
                if (next_state == S_MEASURE)
                    cyc_d = cyc + 1'b1;
                if (SVALID && !abort) begin
                    sum_d   = sum + SW'(SAMPLE);
                    nsamp_d = nsamp + 1'b1;
                end
                if (next_state == S_REPORT) begin
                    pnok_d = 1'b1;
                    err_d  = 1'b1;
                    if (NOK_CNT != '1)
                        nok_d = NOK_CNT + 8'd1;
                end
            end
            S_DECIDE: begin
                if (next_state == S_REPORT) begin
                    if (pass) begin
                        pok_d = 1'b1;
                        if (OK_CNT != '1)
                            ok_d = OK_CNT + 8'd1;
                    end else begin
                        pnok_d = 1'b1;
                        if (NOK_CNT != '1)
                            nok_d = NOK_CNT + 8'd1;
                    end
                end
            end
            S_REPORT: begin
                if (MS) begin
                    pok_d  = 1'b0;
                    pnok_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
